// File: rtl/keypad_code_entry_if.sv
// Keypad-to-lock-core signal bundle: raw key inputs plus passcode bus and command strobes.
// master = keypad_code_entry front end, slave = the keypad/lock-core side.
interface keypad_code_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [11:0] code;
    logic [1:0]  digit_count;
    logic        cmd_unlock;
    logic        cmd_set;
    logic        cmd_lock;
    logic        key_err;
    logic        timeout;

    modport master (
        input  key_valid,
        input  key_code,
        output code,
        output digit_count,
        output cmd_unlock,
        output cmd_set,
        output cmd_lock,
        output key_err,
        output timeout
    );

    modport slave (
        output key_valid,
        output key_code,
        input  code,
        input  digit_count,
        input  cmd_unlock,
        input  cmd_set,
        input  cmd_lock,
        input  key_err,
        input  timeout
    );
endinterface

// File: rtl/keypad_code_entry.sv
// Debounced keypad front end assembling a 3-digit BCD passcode and issuing set/unlock/lock strobes.
// Optional partial-entry expiry is built when ENTRY_TIMEOUT_EN is defined.
module keypad_code_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input logic                 clk,
    input logic                 reset,
    keypad_code_entry_if.master bus
);

    localparam logic [7:0] DebMax = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StIdle, StEntry, StFull, StIssue} state_e;

    logic [3:0]  prev_code_q;
    logic [7:0]  press_cnt_q, press_cnt_d;
    logic [7:0]  rel_cnt_q, rel_cnt_d;
    logic        pressed_q, pressed_d;
    logic        accept;

    state_e      state_q, state_d;
    logic [11:0] code_q, code_d;
    logic [1:0]  count_q, count_d;
    logic        unlock_q, unlock_d;
    logic        set_q, set_d;
    logic        lock_q, lock_d;
    logic        err_q, err_d;
    logic        idle_expire;

    // Debounce: press and release both need DEBOUNCE_CYCLES stable samples; both counters saturate.
    always_comb begin
        press_cnt_d = '0;
        if (bus.key_valid) begin
            if (bus.key_code == prev_code_q) begin
                press_cnt_d = (press_cnt_q == DebMax) ? press_cnt_q : press_cnt_q + 8'd1;
            end else begin
                press_cnt_d = 8'd1;
            end
        end
        rel_cnt_d = '0;
        if (!bus.key_valid) begin
            rel_cnt_d = (rel_cnt_q == DebMax) ? rel_cnt_q : rel_cnt_q + 8'd1;
        end
        accept = !pressed_q && (press_cnt_d == DebMax) && (press_cnt_q != DebMax);
        pressed_d = pressed_q;
        if (accept) begin
            pressed_d = 1'b1;
        end else if (rel_cnt_d == DebMax) begin
            pressed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_code_q <= '0;
            press_cnt_q <= '0;
            rel_cnt_q   <= '0;
            pressed_q   <= 1'b0;
        end else begin
            prev_code_q <= bus.key_code;
            press_cnt_q <= press_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            pressed_q   <= pressed_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             timeout_q;

    // Runs only while a partial or full entry is waiting; any accepted key restarts it.
    always_comb begin
        idle_d = '0;
        if ((state_q == StEntry || state_q == StFull) && !accept) begin
            idle_d = idle_q + 1'b1;
        end
        idle_expire = (idle_d == IdleMax);
        if (idle_expire) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= idle_expire;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign idle_expire = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    function automatic state_e state_for(logic [1:0] cnt);
        if (cnt == 2'd0) begin
            return StIdle;
        end else if (cnt == 2'd3) begin
            return StFull;
        end
        return StEntry;
    endfunction

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        count_d  = count_q;
        unlock_d = 1'b0;
        set_d    = 1'b0;
        lock_d   = 1'b0;
        err_d    = 1'b0;
        if (state_q == StIssue) begin
            // The strobe cycle always ends in a cleared buffer; a key landing here is dropped.
            state_d = StIdle;
            code_d  = '0;
            count_d = '0;
            err_d   = accept;
        end else if (accept) begin
            case (bus.key_code)
                4'd10: begin
                    state_d = StIdle;
                    code_d  = '0;
                    count_d = '0;
                end
                4'd11: begin
                    if (count_q != 2'd0) begin
                        code_d  = {4'h0, code_q[11:4]};
                        count_d = count_q - 2'd1;
                        state_d = state_for(count_q - 2'd1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                4'd12, 4'd13: begin
                    if (state_q == StFull) begin
                        state_d  = StIssue;
                        unlock_d = (bus.key_code == 4'd12);
                        set_d    = (bus.key_code == 4'd13);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                4'd14: begin
                    state_d = StIssue;
                    lock_d  = 1'b1;
                end
                4'd15: begin
                    err_d = 1'b1;
                end
                default: begin
                    if (state_q != StFull) begin
                        code_d  = {code_q[7:0], bus.key_code};
                        count_d = count_q + 2'd1;
                        state_d = state_for(count_q + 2'd1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (idle_expire) begin
            state_d = StIdle;
            code_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            code_q   <= '0;
            count_q  <= '0;
            unlock_q <= 1'b0;
            set_q    <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            count_q  <= count_d;
            unlock_q <= unlock_d;
            set_q    <= set_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.digit_count = count_q;
    assign bus.cmd_unlock  = unlock_q;
    assign bus.cmd_set     = set_q;
    assign bus.cmd_lock    = lock_q;
    assign bus.key_err     = err_q;

endmodule
